// File: rtl/spi_frame_ctrl_pkg.sv
// Shared types for the SPI frame controller: FSM state encoding, widths and
// the helper that left-aligns a frame's payload so its first byte sits on top.
package spi_frame_ctrl_pkg;

    localparam int DATA_W     = 32;
    localparam int BYTE_CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_ACK    = 3'd3,
        ST_BUSY   = 3'd4,
        ST_HOLD   = 3'd5,
        ST_GAP    = 3'd6
    } state_e;

    // Move the (len+1) live bytes to the top so every byte is taken from [31:24].
    function automatic logic [DATA_W-1:0] msb_align(input logic [DATA_W-1:0] p,
                                                    input logic [BYTE_CNT_W-1:0] len);
        logic [DATA_W-1:0] r;
        case (len)
            2'd0:    r = {p[7:0], 24'd0};
            2'd1:    r = {p[15:0], 16'd0};
            2'd2:    r = {p[23:0], 8'd0};
            default: r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_frame_ctrl.sv
// Frames 1-4 bytes for a write-only SPI byte shifter: owns cs_n, setup/hold/gap
// timing and the go/done byte hand-off. The FSM state is mirrored on state_dbg.
module spi_frame_ctrl
    import spi_frame_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4,
    parameter int CNT_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BYTE_CNT_W-1:0] len,
    input  logic [DATA_W-1:0]     payload,
    output logic                  ready,
    output logic                  frame_done,
    output logic                  cs_n,
    output logic                  spi_go,
    output logic [7:0]            spi_data,
    input  logic                  spi_done,
    output state_e                state_dbg
);

    // Handshake: a frame is accepted on a posedge where start && ready; a byte
    // is handed off by a one-cycle spi_go while spi_done was high, the shifter
    // acknowledges by dropping spi_done and signals completion by raising it.

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]     latch_q, latch_d;
    logic [BYTE_CNT_W-1:0] rem_q, rem_d;
    logic                  cs_n_q, cs_n_d;
    logic                  spi_go_q, spi_go_d;
    logic [7:0]            spi_data_q, spi_data_d;
    logic                  frame_done_q, frame_done_d;

    assign ready      = (state_q == ST_IDLE) && spi_done;
    assign frame_done = frame_done_q;
    assign cs_n       = cs_n_q;
    assign spi_go     = spi_go_q;
    assign spi_data   = spi_data_q;
    assign state_dbg  = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        latch_d      = latch_q;
        rem_d        = rem_q;
        cs_n_d       = cs_n_q;
        spi_go_d     = 1'b0;
        spi_data_d   = spi_data_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start && ready) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    latch_d = msb_align(payload, len);
                    rem_d   = len;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_BITS'(SETUP_CYC - 1)) begin
                    state_d = ST_LAUNCH;
                    cnt_d   = '0;
                end
            end
            ST_LAUNCH: begin
                cnt_d = '0;
                // Guard keeps go off while a shifter left running by a reset is still busy.
                if (spi_done) begin
                    spi_go_d   = 1'b1;
                    spi_data_d = latch_q[DATA_W-1 -: 8];
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                cnt_d = '0;
                if (!spi_done) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = '0;
                if (spi_done) begin
                    if (rem_q != '0) begin
                        latch_d = latch_q << 8;
                        rem_d   = rem_q - 2'd1;
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_BITS'(HOLD_CYC - 1)) begin
                    cs_n_d       = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_BITS'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            latch_q      <= '0;
            rem_q        <= '0;
            cs_n_q       <= 1'b1;
            spi_go_q     <= 1'b0;
            spi_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            rem_q        <= rem_d;
            cs_n_q       <= cs_n_d;
            spi_go_q     <= spi_go_d;
            spi_data_q   <= spi_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
